serial_adder: RTL
=================

// Module: serial_adder
// PURPOSE
//  Multi-cycle parametrised adder/subtractor for the 64-bit ALU datapath.
//  It adds DIGIT bits per clock, using DIGIT-bit full-adder slices, until all WIDTH bits are done.
//  It returns z and c_out through a start/busy/done handshake.
//  It replaces the combinational full-adder chain where area matters more than latency.
// PARAMETERS
//  WIDTH  64  operand/result width in bits
//  DIGIT  8   bits processed per cycle; WIDTH % DIGIT == 0 required (elaboration-time error otherwise)
// PORTS
//  clk    in   1      clock; all state updates on rising edge
//  rst_b  in   1      reset, asynchronous, active-low
//  start  in   1      request; sampled only while busy==0
//  sub    in   1      0: z = x + y + c_in;  1: z = x - y (c_in ignored, computed as x + ~y + 1)
//  x      in   WIDTH  operand A, captured on accepted start
//  y      in   WIDTH  operand B, captured on accepted start
//  c_in   in   1      carry in, captured on accepted start
//  z      out  WIDTH  result; held until the next result is written
//  c_out  out  1      carry out of bit WIDTH-1 (sub: 1 = no borrow)
//  ovf    out  1      signed overflow (see CONFIGURATION)
//  busy   out  1      high while a computation is in progress
//  done   out  1      one-cycle pulse when z/c_out/ovf have just been updated
// BEHAVIOUR
//  - STEPS = WIDTH/DIGIT. FSM states: IDLE, RUN, DONE.
//  - Reset (rst_b==0, async): state=IDLE. z, c_out, ovf, busy, done and internal regs = 0.
//  - IDLE/DONE with start==1:
//      capture x; capture y (or ~y if sub); carry = sub ? 1 : c_in; step counter = 0.
//      Go to RUN; busy=1 from the next cycle.
//  - IDLE/DONE with start==0: go to / stay in IDLE. done=0.
//  - RUN, each cycle:
//      add digit[cnt] of both operands plus carry; store the DIGIT-bit sum in the accumulator;
//      carry <= digit carry out; cnt++.
//  - RUN, after the digit with cnt==STEPS-1:
//      state=DONE; z <= accumulator; c_out <= final carry; ovf updated.
//      busy=0 and done=1 during the DONE cycle.
//  - Latency: start sampled at edge N -> done high in cycle N+STEPS+1 (9 cycles at defaults).
//  - z, c_out and ovf do not change during RUN; they keep the previous result.
//  - start while busy==1 is ignored and has no effect on the computation in flight.
//  - start during the DONE cycle is accepted: back-to-back operation with no idle gap.
//  - Operand inputs may change freely after the start edge.
//  - Reset mid-RUN aborts the computation: no done pulse, outputs go to 0.
//  - Wrap-around: the result is modulo 2^WIDTH; the carry leaves only via c_out.
// CONFIGURATION
//  SERIAL_ADDER_OVF_EN
//    defined: ovf <= (xa[W-1]==yb[W-1]) && (sum[W-1]!=xa[W-1]), updated with z.
//      xa = captured x; yb = captured effective y (~y when sub).
//    undefined: ovf tied to 0; no overflow logic is built.
// TESTING (WIDTH=64, DIGIT=8)
//  1. rst_b=0 mid-idle -> z=0, c_out=0, ovf=0, busy=0, done=0 immediately (asynchronous).
//  2. x=FFFF_FFFF_FFFF_FFFF, y=0, c_in=1, sub=0, start pulse:
//     -> busy high for 8 cycles; done in cycle 9; z=0, c_out=1.
//  3. x=5, y=7, sub=1 -> z=FFFF_FFFF_FFFF_FFFE, c_out=0; ovf=0 with the macro.
//  4. With the macro, x=7FFF_FFFF_FFFF_FFFF, y=1, sub=0, c_in=0:
//     -> z=8000_0000_0000_0000, ovf=1, c_out=0. Without the macro: ovf=0.
//  5. Re-pulse start with new operands at cycle 3 of RUN -> ignored; first result unchanged.
//     Start again in the done cycle -> second result arrives 9 cycles later.
//  6. rst_b low for one cycle at RUN cycle 4 -> no done pulse; all outputs 0.
//     A new start afterwards completes normally.

Source files
------------

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, result and carry via start/busy/done.
// Define SERIAL_ADDER_OVF_EN to build the signed-overflow flag; otherwise ovf is tied to 0.
module serial_adder #(
    parameter int WIDTH = 64,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c_in,
    output logic [WIDTH-1:0] z,
    output logic             c_out,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    generate
        if ((WIDTH % DIGIT) != 0 || DIGIT < 1) begin : g_bad_params
            $error("serial_adder: WIDTH must be a nonzero multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] xa;
    logic [WIDTH-1:0] yb;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             carry;

    logic             accept;
    logic             last;
    logic [DIGIT-1:0] dsum;
    logic             dcarry;
    logic [WIDTH+DIGIT-1:0] acc_cat;
    logic [WIDTH-1:0] acc_next;

    assign accept = (state != RUN) && start;
    assign last   = (state == RUN) && (cnt == CW'(STEPS - 1));
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    // Operands shift right each step, so the active digit always sits in the low DIGIT bits.
    assign {dcarry, dsum} = {1'b0, xa[DIGIT-1:0]} + {1'b0, yb[DIGIT-1:0]} + (DIGIT + 1)'(carry);

    // New digit enters at the top; after STEPS shifts the accumulator holds the full sum in order.
    assign acc_cat  = {dsum, acc};
    assign acc_next = acc_cat[WIDTH+DIGIT-1:DIGIT];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = start ? RUN : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            xa    <= '0;
            yb    <= '0;
            acc   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            z     <= '0;
            c_out <= 1'b0;
        end else if (accept) begin
            xa    <= x;
            yb    <= sub ? ~y : y;
            carry <= sub ? 1'b1 : c_in;
            cnt   <= '0;
        end else if (state == RUN) begin
            xa    <= xa >> DIGIT;
            yb    <= yb >> DIGIT;
            acc   <= acc_next;
            carry <= dcarry;
            cnt   <= cnt + CW'(1);
            if (last) begin
                z     <= acc_next;
                c_out <= dcarry;
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // On the last step the low digit of xa/yb holds the original sign bits.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ovf <= 1'b0;
        end else if (last) begin
            ovf <= (xa[DIGIT-1] == yb[DIGIT-1]) && (dsum[DIGIT-1] != xa[DIGIT-1]);
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule
